// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block for the pipelined core.
// Holds the UART RX FIFO, the UART TX holding register and N_CNT event counters.
// Loads return data one cycle after re, matching the synchronous dmem/biosmem latency.
// Optional feature: define MMIO_CNT_FREEZE_EN to map a counter-freeze register at 0x1C.
module mmio_ctrl #(
  parameter int unsigned N_CNT    = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic             we,
  output logic [31:0]      rdata,
  input  logic             uart_rx_valid,
  input  logic [7:0]       uart_rx_data,
  output logic             uart_rx_ready,
  output logic             uart_tx_valid,
  output logic [7:0]       uart_tx_data,
  input  logic             uart_tx_ready,
  input  logic [N_CNT-1:0] cnt_event
);

  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam logic [PTR_W:0] RxFull = (PTR_W + 1)'(RX_DEPTH);

  // Address decode
  logic       io_hit;
  logic       io_rd;
  logic       io_wr;
  logic [7:0] off;

  assign io_hit = (addr[31:30] == 2'b10);
  assign io_rd  = re && io_hit;
  assign io_wr  = we && io_hit;
  assign off    = addr[7:0];

  // Address/data bits that play no part in the decode
  logic unused_bits;
  assign unused_bits = ^{addr[29:8], wdata[31:8]};

  // RX FIFO state
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr_q;
  logic [PTR_W-1:0] rx_rd_ptr_q;
  logic [PTR_W:0]   rx_fill_q;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic             rx_pop;
  logic [7:0]       rx_head;

  assign rx_full  = (rx_fill_q == RxFull);
  assign rx_empty = (rx_fill_q == '0);
  // Push is gated on the registered full flag, so a pop from a full FIFO
  // only frees space for the following cycle.
  assign rx_push  = uart_rx_valid && !rx_full;
  // The pop sees pre-push occupancy: no fall-through from an empty FIFO.
  assign rx_pop   = io_rd && (off == 8'h04) && !rx_empty;
  assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];

  assign uart_rx_ready = !rx_full;

  // TX holding register state
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       tx_load;

  assign tx_load       = io_wr && (off == 8'h08) && !tx_valid_q;
  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_data_q;

  // Counter state
  logic [CNT_W-1:0] cnt_q [N_CNT];
  logic             cnt_clr;
  logic             freeze;

  assign cnt_clr = io_wr && (off == 8'h18);

`ifdef MMIO_CNT_FREEZE_EN
  logic freeze_q;

  // Freeze control register at 0x1C, bit0 only
  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_q <= 1'b0;
    end else if (io_wr && (off == 8'h1C)) begin
      freeze_q <= wdata[0];
    end
  end

  assign freeze = freeze_q;
`else
  assign freeze = 1'b0;
`endif

  // RX FIFO storage; contents past the pointers are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr_q] <= uart_rx_data;
    end
  end

  // RX FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_fill_q   <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_fill_q <= rx_fill_q + 1'b1;
        2'b01:   rx_fill_q <= rx_fill_q - 1'b1;
        default: rx_fill_q <= rx_fill_q;
      endcase
    end
  end

  // TX holding register: load only when empty, release on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (tx_load) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= wdata[7:0];
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  // Event counters; clear takes priority over freeze and events
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < int'(N_CNT); i++) begin
        cnt_q[i] <= '0;
      end
    end else if (!freeze) begin
      for (int i = 0; i < int'(N_CNT); i++) begin
        if (cnt_event[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Read data mux; the freeze register shadows a counter mapped at 0x1C
  logic [31:0] rd_val;

  always_comb begin
    rd_val = 32'h0;
    case (off)
      8'h00: rd_val = {30'b0, !rx_empty, !tx_valid_q};
      8'h04: rd_val = {24'b0, rx_head};
`ifdef MMIO_CNT_FREEZE_EN
      8'h1C: rd_val = {31'b0, freeze_q};
`endif
      default: begin
        for (int i = 0; i < int'(N_CNT); i++) begin
          if (off == 8'(16 + 4 * i)) begin
            rd_val = 32'(cnt_q[i]);
          end
        end
      end
    endcase
  end

  // Registered load data; holds when no IO read is issued
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (io_rd) begin
      rdata_q <= rd_val;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed testbench for mmio_ctrl. A second instance with CNT_W=4 checks counter wrap.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [31:0] rdata;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_ready;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;
  logic [1:0]  cnt_event;

  logic [31:0] rdata4;
  logic        rx_ready4;
  logic        tx_valid4;
  logic [7:0]  tx_data4;
  logic [1:0]  ev4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mmio_ctrl #(.N_CNT(2), .CNT_W(32), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .re(re), .we(we), .rdata(rdata),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .cnt_event(cnt_event)
  );

  mmio_ctrl #(.N_CNT(2), .CNT_W(4), .RX_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .re(re), .we(we), .rdata(rdata4),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(rx_ready4),
    .uart_tx_valid(tx_valid4), .uart_tx_data(tx_data4), .uart_tx_ready(uart_tx_ready),
    .cnt_event(ev4)
  );

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0);
    end
    nvec++;
    if (uart_rx_ready !== 1'b1 || uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00) begin
      nerr++; $display("FAIL reset_uart got rdy=%b txv=%b txd=%h want 1 0 00",
                       uart_rx_ready, uart_tx_valid, uart_tx_data);
    end
    do_read(32'h8000_0000);
    nvec++;
    if (rdata !== 32'h1) begin
      nerr++; $display("FAIL reset_status got %h want %h", rdata, 32'h1);
    end
    do_read(32'h8000_0010);
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL reset_cnt0 got %h want %h", rdata, 32'h0);
    end
    do_read(32'h8000_0014);
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL reset_cnt1 got %h want %h", rdata, 32'h0);
    end
  endtask

  task automatic test_decode();
    // Non-IO read leaves rdata holding the status value
    do_read(32'h8000_0000);
    do_read(32'h0000_0000);
    nvec++;
    if (rdata !== 32'h1) begin
      nerr++; $display("FAIL nonio_read_hold got %h want %h", rdata, 32'h1);
    end
    do_read(32'h8000_0040);
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL unmapped_read got %h want %h", rdata, 32'h0);
    end
    // Non-IO store to the TX offset must not load the TX register
    do_write(32'h0000_0008, 32'h77);
    nvec++;
    if (uart_tx_valid !== 1'b0) begin
      nerr++; $display("FAIL nonio_write got txv=%b want 0", uart_tx_valid);
    end
  endtask

  task automatic test_rx_fifo();
    for (int i = 0; i < 4; i++) begin
      uart_rx_data  = 8'h41 + 8'(i);
      uart_rx_valid = 1'b1;
      tick();
    end
    uart_rx_data = 8'h45;
    nvec++;
    if (uart_rx_ready !== 1'b0) begin
      nerr++; $display("FAIL rx_full_ready got %b want 0", uart_rx_ready);
    end
    tick();
    uart_rx_valid = 1'b0;
    do_read(32'h8000_0000);
    nvec++;
    if (rdata !== 32'h3) begin
      nerr++; $display("FAIL rx_status_full got %h want %h", rdata, 32'h3);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(32'h8000_0004);
      nvec++;
      if (rdata !== 32'h41 + 32'(i)) begin
        nerr++; $display("FAIL rx_pop%0d got %h want %h", i, rdata, 32'h41 + 32'(i));
      end
    end
    do_read(32'h8000_0004);
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL rx_pop_empty got %h want %h", rdata, 32'h0);
    end
    do_read(32'h8000_0000);
    nvec++;
    if (rdata !== 32'h1) begin
      nerr++; $display("FAIL rx_status_empty got %h want %h", rdata, 32'h1);
    end
  endtask

  task automatic test_back_to_back();
    // Fill, then push and pop together while full: only the pop happens
    for (int i = 0; i < 4; i++) begin
      uart_rx_data  = 8'h10 + 8'(i);
      uart_rx_valid = 1'b1;
      tick();
    end
    uart_rx_data = 8'h55;
    do_read(32'h8000_0004);
    nvec++;
    if (rdata !== 32'h10 || uart_rx_ready !== 1'b1) begin
      nerr++; $display("FAIL full_push_pop got rd=%h rdy=%b want 10 1", rdata, uart_rx_ready);
    end
    tick();
    uart_rx_valid = 1'b0;
    nvec++;
    if (uart_rx_ready !== 1'b0) begin
      nerr++; $display("FAIL refill_ready got %b want 0", uart_rx_ready);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp;
      exp = (i == 3) ? 32'h55 : 32'h11 + 32'(i);
      do_read(32'h8000_0004);
      nvec++;
      if (rdata !== exp) begin
        nerr++; $display("FAIL refill_pop%0d got %h want %h", i, rdata, exp);
      end
    end
    // Push into empty FIFO concurrent with a pop: no fall-through
    uart_rx_data  = 8'h66;
    uart_rx_valid = 1'b1;
    do_read(32'h8000_0004);
    uart_rx_valid = 1'b0;
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL empty_fallthrough got %h want %h", rdata, 32'h0);
    end
    // Push and pop while partially full keeps order
    uart_rx_data  = 8'h70;
    uart_rx_valid = 1'b1;
    do_read(32'h8000_0004);
    uart_rx_valid = 1'b0;
    nvec++;
    if (rdata !== 32'h66) begin
      nerr++; $display("FAIL mid_push_pop got %h want %h", rdata, 32'h66);
    end
    do_read(32'h8000_0004);
    nvec++;
    if (rdata !== 32'h70) begin
      nerr++; $display("FAIL mid_pop_next got %h want %h", rdata, 32'h70);
    end
  endtask

  task automatic test_tx();
    uart_tx_ready = 1'b0;
    do_write(32'h8000_0008, 32'h5A);
    nvec++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h5A) begin
      nerr++; $display("FAIL tx_load got v=%b d=%h want 1 5a", uart_tx_valid, uart_tx_data);
    end
    tick();
    tick();
    do_write(32'h8000_0008, 32'h33);
    nvec++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h5A) begin
      nerr++; $display("FAIL tx_drop got v=%b d=%h want 1 5a", uart_tx_valid, uart_tx_data);
    end
    do_read(32'h8000_0000);
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL tx_status_busy got %h want %h", rdata, 32'h0);
    end
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    nvec++;
    if (uart_tx_valid !== 1'b0) begin
      nerr++; $display("FAIL tx_release got v=%b want 0", uart_tx_valid);
    end
    do_read(32'h8000_0000);
    nvec++;
    if (rdata !== 32'h1) begin
      nerr++; $display("FAIL tx_status_idle got %h want %h", rdata, 32'h1);
    end
  endtask

  task automatic test_counters();
    do_write(32'h8000_0018, 32'h0);
    cnt_event = 2'b01;
    repeat (100) @(posedge clk);
    #1;
    cnt_event = 2'b00;
    do_read(32'h8000_0010);
    nvec++;
    if (rdata !== 32'd100) begin
      nerr++; $display("FAIL cnt0_100 got %0d want %0d", rdata, 100);
    end
    do_read(32'h8000_0014);
    nvec++;
    if (rdata !== 32'd0) begin
      nerr++; $display("FAIL cnt1_idle got %0d want %0d", rdata, 0);
    end
    cnt_event = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    cnt_event = 2'b00;
    do_read(32'h8000_0014);
    nvec++;
    if (rdata !== 32'd5) begin
      nerr++; $display("FAIL cnt1_5 got %0d want %0d", rdata, 5);
    end
    // Clear in the same cycle as an event on both counters
    cnt_event = 2'b11;
    do_write(32'h8000_0018, 32'h0);
    cnt_event = 2'b00;
    do_read(32'h8000_0010);
    nvec++;
    if (rdata !== 32'd0) begin
      nerr++; $display("FAIL clr_cnt0 got %0d want %0d", rdata, 0);
    end
    do_read(32'h8000_0014);
    nvec++;
    if (rdata !== 32'd0) begin
      nerr++; $display("FAIL clr_cnt1 got %0d want %0d", rdata, 0);
    end
  endtask

  task automatic test_cnt_wrap();
    do_write(32'h8000_0018, 32'h0);
    ev4 = 2'b01;
    repeat (17) @(posedge clk);
    #1;
    ev4 = 2'b00;
    do_read(32'h8000_0010);
    nvec++;
    if (rdata4 !== 32'h1) begin
      nerr++; $display("FAIL cnt_wrap got %h want %h", rdata4, 32'h1);
    end
  endtask

  task automatic test_freeze();
`ifdef MMIO_CNT_FREEZE_EN
    do_write(32'h8000_0018, 32'h0);
    do_write(32'h8000_001C, 32'h1);
    cnt_event = 2'b01;
    repeat (50) @(posedge clk);
    #1;
    cnt_event = 2'b00;
    do_read(32'h8000_0010);
    nvec++;
    if (rdata !== 32'd0) begin
      nerr++; $display("FAIL frozen_cnt got %0d want %0d", rdata, 0);
    end
    do_read(32'h8000_001C);
    nvec++;
    if (rdata !== 32'h1) begin
      nerr++; $display("FAIL freeze_reg got %h want %h", rdata, 32'h1);
    end
    do_write(32'h8000_001C, 32'h0);
    cnt_event = 2'b01;
    repeat (10) @(posedge clk);
    #1;
    cnt_event = 2'b00;
    do_read(32'h8000_0010);
    nvec++;
    if (rdata !== 32'd10) begin
      nerr++; $display("FAIL resumed_cnt got %0d want %0d", rdata, 10);
    end
`else
    do_read(32'h8000_0000);
    do_read(32'h8000_001C);
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL freeze_unmapped got %h want %h", rdata, 32'h0);
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    uart_tx_ready = 1'b0;
    do_write(32'h8000_0008, 32'hA5);
    uart_rx_data  = 8'h99;
    uart_rx_valid = 1'b1;
    tick();
    tick();
    uart_rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00 || uart_rx_ready !== 1'b1) begin
      nerr++; $display("FAIL midrst_uart got txv=%b txd=%h rdy=%b want 0 00 1",
                       uart_tx_valid, uart_tx_data, uart_rx_ready);
    end
    do_read(32'h8000_0000);
    nvec++;
    if (rdata !== 32'h1) begin
      nerr++; $display("FAIL midrst_status got %h want %h", rdata, 32'h1);
    end
  endtask

  initial begin
    rst           = 1'b1;
    addr          = 32'h0;
    wdata         = 32'h0;
    re            = 1'b0;
    we            = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_tx_ready = 1'b0;
    cnt_event     = 2'b00;
    ev4           = 2'b00;
    #1;
    test_reset();
    test_decode();
    test_rx_fifo();
    test_back_to_back();
    test_tx();
    test_counters();
    test_cnt_wrap();
    test_freeze();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
